dm_halt_ctrl: RTL and testbench
===============================

DM_HALT_CTRL -- requirements
Module: dm_halt_ctrl

Interface
REQ-001 SHALL have parameter NrHarts, default 1, number of controlled harts (1..32).
REQ-002 SHALL have parameter DataCount, default 4'h2, number of abstract data registers reported (1..12).
REQ-003 SHALL have parameter DataAddr, default 12'h380, first CSR address shadowing data0.
REQ-004 SHALL have parameter HaltAddress, default 64'h800; resume address = HaltAddress+4.
REQ-005 SHALL have the port list below, in this order: clk_i, rst_i, then per-hart vectors indexed by hart number.
REQ-006 SHALL use one clock, clk_i; reset rst_i SHALL be synchronous and active-high.
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- haltreq_i  in  NrHarts  halt request level from DMI
- resumereq_i  in  NrHarts  resume request, one-cycle pulse
- step_i  in  NrHarts  dcsr.step of each hart
- breakpoint_i  in  NrHarts  hart executed ebreak into debug
- trigger_i  in  NrHarts  hart trigger fired into debug
- halted_i  in  NrHarts  hart reports parked at HaltAddress, one-cycle pulse
- running_i  in  NrHarts  hart reports left park loop, one-cycle pulse
- debug_req_o  out  NrHarts  debug request to core
- resume_o  out  NrHarts  one-cycle pulse: jump to HaltAddress+4
- halted_o  out  NrHarts  hart halted
- resumeack_o  out  NrHarts  sticky resume acknowledge
- cause_o  out  3*NrHarts  dcsr.cause per hart
- anyhalted_o, allhalted_o  out  1 each  summary
- hartinfo_o  out  32  hartinfo_t word

Function
REQ-007 SHALL run one independent FSM per hart: RUNNING, HALT_PEND, HALTED, RESUME_PEND, STEPPING.
REQ-008 In RUNNING, a halt source SHALL move to HALT_PEND next cycle and latch cause with priority Trigger(3'h2) > Breakpoint(3'h1) > Request(3'h3).
REQ-009 debug_req_o SHALL be 1 only in HALT_PEND with cause Request, held until halted_i.
REQ-010 In HALT_PEND, halted_i SHALL move to HALTED next cycle; halted_o=1 exactly in HALTED.
REQ-011 In HALTED, resumereq_i with haltreq_i=0 SHALL clear resumeack_o, pulse resume_o next cycle, enter RESUME_PEND; resumereq_i with haltreq_i=1 SHALL be ignored.
REQ-012 In RESUME_PEND, running_i SHALL set resumeack_o and enter STEPPING if step_i=1, else RUNNING.
REQ-013 In STEPPING, halted_i SHALL enter HALTED with cause SingleStep (3'h4) unless trigger_i is simultaneously 1 (cause Trigger).
REQ-014 In STEPPING, haltreq_i SHALL NOT assert debug_req_o; the step halt satisfies it.
REQ-015 halted_i in RUNNING (unsolicited) SHALL enter HALTED with cause Breakpoint if breakpoint_i=1, else Request.
REQ-016 halted_i/running_i in states not listed SHALL be ignored.
REQ-017 resumeack_o SHALL stay 1 until the next accepted resumereq_i.
REQ-018 anyhalted_o = OR of halted_o; allhalted_o = AND of halted_o; both combinational from registered state.
REQ-019 hartinfo_o SHALL be constant: zero1=0, nscratch=2, zero0=0, dataaccess=1, datasize=DataCount, dataaddr=DataAddr.

Reset
REQ-020 rst_i SHALL put every hart in RUNNING; debug_req_o=0, resume_o=0, halted_o=0, resumeack_o=0, cause_o=0, anyhalted_o=0, allhalted_o=0.
REQ-021 rst_i asserted mid-operation SHALL override all inputs; outputs reach reset values the cycle after the reset edge.

Structure
REQ-022 hartinfo_t, cause constants, HaltAddress and the hart state enum SHALL reside in the shared debug package.
REQ-023 The per-hart FSM SHALL be a sub-module dm_hart_fsm, instantiated NrHarts times by generate.

Verification
REQ-024 NrHarts=2, haltreq_i[0]=1, halted_i[0] pulse 3 cycles later -> debug_req_o[0] high 3 cycles, halted_o=2'b01, cause_o[0]=3'h3, anyhalted_o=1, allhalted_o=0.
REQ-025 Hart 0 halted, resumereq_i[0] pulse, running_i[0] 2 cycles later -> resume_o[0] one pulse, resumeack_o[0] 0 then 1, state RUNNING.
REQ-026 step_i=1, resume, running_i, halted_i -> halted_o=1, cause 3'h4, debug_req_o never asserted.
REQ-027 trigger_i and haltreq_i same cycle in RUNNING -> cause 3'h2, debug_req_o stays 0.
REQ-028 Hart in HALT_PEND, rst_i one cycle -> all outputs at reset values; hartinfo_o = 32'h0021_2380 for defaults.

Source files
------------

// File: rtl/dm_halt_ctrl_pkg.sv
// Shared debug-module types and constants: hart FSM states, dcsr.cause encodings,
// hartinfo layout and the default park-loop address.
package dm_halt_ctrl_pkg;

  localparam int unsigned CauseW = 3;

  localparam logic [CauseW-1:0] CauseNone       = 3'h0;
  localparam logic [CauseW-1:0] CauseBreakpoint = 3'h1;
  localparam logic [CauseW-1:0] CauseTrigger    = 3'h2;
  localparam logic [CauseW-1:0] CauseRequest    = 3'h3;
  localparam logic [CauseW-1:0] CauseSingleStep = 3'h4;

  localparam logic [63:0] DefaultHaltAddress = 64'h800;

  typedef enum logic [2:0] {
    HartRunning    = 3'd0,
    HartHaltPend   = 3'd1,
    HartHalted     = 3'd2,
    HartResumePend = 3'd3,
    HartStepping   = 3'd4
  } hart_state_e;

  typedef struct packed {
    logic [7:0]  zero1;
    logic [3:0]  nscratch;
    logic [2:0]  zero0;
    logic        dataaccess;
    logic [3:0]  datasize;
    logic [11:0] dataaddr;
  } hartinfo_t;

  // Trigger outranks breakpoint, which outranks an external halt request.
  function automatic logic [CauseW-1:0] halt_cause(input logic trigger, input logic breakpoint);
    if (trigger)         return CauseTrigger;
    else if (breakpoint) return CauseBreakpoint;
    else                 return CauseRequest;
  endfunction

  function automatic logic [63:0] resume_addr(input logic [63:0] halt_addr);
    return halt_addr + 64'd4;
  endfunction

endpackage

// File: rtl/dm_halt_ctrl_if.sv
// Per-hart halt/resume handshake bundle between the debug module and its harts.
interface dm_halt_ctrl_if #(
  parameter int unsigned N = 1
);
  logic [N-1:0]   haltreq;
  logic [N-1:0]   resumereq;
  logic [N-1:0]   step;
  logic [N-1:0]   breakpoint;
  logic [N-1:0]   trigger;
  logic [N-1:0]   hart_halted;
  logic [N-1:0]   hart_running;
  logic [N-1:0]   debug_req;
  logic [N-1:0]   resume;
  logic [N-1:0]   halted;
  logic [N-1:0]   resumeack;
  logic [3*N-1:0] cause;

  modport master (
    output haltreq, resumereq, step, breakpoint, trigger, hart_halted, hart_running,
    input  debug_req, resume, halted, resumeack, cause
  );

  modport slave (
    input  haltreq, resumereq, step, breakpoint, trigger, hart_halted, hart_running,
    output debug_req, resume, halted, resumeack, cause
  );
endinterface

// File: rtl/dm_hart_fsm.sv
// Halt/resume/step state machine for a single hart; all outputs are registered.
module dm_hart_fsm
  import dm_halt_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  dm_halt_ctrl_if.slave  bus
);

  hart_state_e state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= HartRunning;
      bus.debug_req <= 1'b0;
      bus.resume    <= 1'b0;
      bus.halted    <= 1'b0;
      bus.resumeack <= 1'b0;
      bus.cause     <= CauseNone;
    end else begin
      bus.resume <= 1'b0;
      unique case (state)
        HartRunning: begin
          // An unsolicited park report skips the pending phase entirely.
          if (bus.hart_halted[0]) begin
            state      <= HartHalted;
            bus.halted <= 1'b1;
            bus.cause  <= bus.breakpoint[0] ? CauseBreakpoint : CauseRequest;
          end else if (bus.trigger[0] || bus.breakpoint[0] || bus.haltreq[0]) begin
            state         <= HartHaltPend;
            bus.cause     <= halt_cause(bus.trigger[0], bus.breakpoint[0]);
            bus.debug_req <= !bus.trigger[0] && !bus.breakpoint[0];
          end
        end
        HartHaltPend: begin
          if (bus.hart_halted[0]) begin
            state         <= HartHalted;
            bus.halted    <= 1'b1;
            bus.debug_req <= 1'b0;
          end
        end
        HartHalted: begin
          // A still-asserted halt request blocks the resume.
          if (bus.resumereq[0] && !bus.haltreq[0]) begin
            state         <= HartResumePend;
            bus.halted    <= 1'b0;
            bus.resume    <= 1'b1;
            bus.resumeack <= 1'b0;
          end
        end
        HartResumePend: begin
          if (bus.hart_running[0]) begin
            state         <= bus.step[0] ? HartStepping : HartRunning;
            bus.resumeack <= 1'b1;
          end
        end
        HartStepping: begin
          // Halt requests are left to the step halt; no debug_req here.
          if (bus.hart_halted[0]) begin
            state      <= HartHalted;
            bus.halted <= 1'b1;
            bus.cause  <= bus.trigger[0] ? CauseTrigger : CauseSingleStep;
          end
        end
        default: begin
          state         <= HartRunning;
          bus.debug_req <= 1'b0;
          bus.halted    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/dm_halt_ctrl.sv
// Debug-module halt controller: one dm_hart_fsm per hart plus halt summaries and hartinfo.
module dm_halt_ctrl
  import dm_halt_ctrl_pkg::*;
#(
  parameter int unsigned NrHarts     = 1,
  parameter logic [3:0]  DataCount   = 4'h2,
  parameter logic [11:0] DataAddr    = 12'h380,
  parameter logic [63:0] HaltAddress = DefaultHaltAddress
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NrHarts-1:0]     haltreq_i,
  input  logic [NrHarts-1:0]     resumereq_i,
  input  logic [NrHarts-1:0]     step_i,
  input  logic [NrHarts-1:0]     breakpoint_i,
  input  logic [NrHarts-1:0]     trigger_i,
  input  logic [NrHarts-1:0]     halted_i,
  input  logic [NrHarts-1:0]     running_i,
  output logic [NrHarts-1:0]     debug_req_o,
  output logic [NrHarts-1:0]     resume_o,
  output logic [NrHarts-1:0]     halted_o,
  output logic [NrHarts-1:0]     resumeack_o,
  output logic [3*NrHarts-1:0]   cause_o,
  output logic                   anyhalted_o,
  output logic                   allhalted_o,
  output logic [31:0]            hartinfo_o
);

  // Elaboration-time parameter sanity checks.
  if (NrHarts < 1 || NrHarts > 32) begin : g_bad_nrharts
    $error("dm_halt_ctrl: NrHarts out of range");
  end
  if (DataCount < 4'd1 || DataCount > 4'd12) begin : g_bad_datacount
    $error("dm_halt_ctrl: DataCount out of range");
  end
  if (HaltAddress[1:0] != 2'b00) begin : g_bad_haltaddr
    $error("dm_halt_ctrl: HaltAddress must be word aligned");
  end

  for (genvar h = 0; h < NrHarts; h++) begin : g_hart
    dm_halt_ctrl_if #(.N(1)) hart_if ();

    assign hart_if.haltreq      = haltreq_i[h];
    assign hart_if.resumereq    = resumereq_i[h];
    assign hart_if.step         = step_i[h];
    assign hart_if.breakpoint   = breakpoint_i[h];
    assign hart_if.trigger      = trigger_i[h];
    assign hart_if.hart_halted  = halted_i[h];
    assign hart_if.hart_running = running_i[h];

    dm_hart_fsm u_fsm (
      .clk (clk_i),
      .rst (rst_i),
      .bus (hart_if.slave)
    );

    assign debug_req_o[h]       = hart_if.debug_req;
    assign resume_o[h]          = hart_if.resume;
    assign halted_o[h]          = hart_if.halted;
    assign resumeack_o[h]       = hart_if.resumeack;
    assign cause_o[3*h +: 3]    = hart_if.cause;
  end

  assign anyhalted_o = |halted_o;
  assign allhalted_o = &halted_o;

  hartinfo_t hartinfo;
  always_comb begin
    hartinfo            = '0;
    hartinfo.nscratch   = 4'd2;
    hartinfo.dataaccess = 1'b1;
    hartinfo.datasize   = DataCount;
    hartinfo.dataaddr   = DataAddr;
  end
  assign hartinfo_o = hartinfo;

endmodule

// File: tb/tb_dm_halt_ctrl.sv
// Directed self-checking bench for dm_halt_ctrl with two harts.
module tb_dm_halt_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic anyhalted, allhalted;
  logic [31:0] hartinfo;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  dm_halt_ctrl_if #(.N(2)) dbg ();

  dm_halt_ctrl #(.NrHarts(2)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .haltreq_i    (dbg.haltreq),
    .resumereq_i  (dbg.resumereq),
    .step_i       (dbg.step),
    .breakpoint_i (dbg.breakpoint),
    .trigger_i    (dbg.trigger),
    .halted_i     (dbg.hart_halted),
    .running_i    (dbg.hart_running),
    .debug_req_o  (dbg.debug_req),
    .resume_o     (dbg.resume),
    .halted_o     (dbg.halted),
    .resumeack_o  (dbg.resumeack),
    .cause_o      (dbg.cause),
    .anyhalted_o  (anyhalted),
    .allhalted_o  (allhalted),
    .hartinfo_o   (hartinfo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    dbg.haltreq      = '0;
    dbg.resumereq    = '0;
    dbg.step         = '0;
    dbg.breakpoint   = '0;
    dbg.trigger      = '0;
    dbg.hart_halted  = '0;
    dbg.hart_running = '0;
    tick();
    tick();
    check("rst_debug_req", 32'(dbg.debug_req), 32'h0);
    check("rst_resume",    32'(dbg.resume),    32'h0);
    check("rst_halted",    32'(dbg.halted),    32'h0);
    check("rst_resumeack", 32'(dbg.resumeack), 32'h0);
    check("rst_cause",     32'(dbg.cause),     32'h0);
    check("rst_any",       32'(anyhalted),     32'h0);
    check("rst_all",       32'(allhalted),     32'h0);
    check("hartinfo",      hartinfo,           32'h0021_2380);
    rst = 1'b0;

    // Halt request on hart 0; park report three cycles later.
    dbg.haltreq = 2'b01;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("req_debug_req_high", 32'(dbg.debug_req), 32'h1);
      check("req_not_halted",     32'(dbg.halted),    32'h0);
    end
    dbg.hart_halted = 2'b01;
    tick();
    dbg.hart_halted = 2'b00;
    check("req_debug_req_low", 32'(dbg.debug_req), 32'h0);
    check("req_halted",        32'(dbg.halted),    32'h1);
    check("req_cause",         32'(dbg.cause),     32'h3);
    check("req_any",           32'(anyhalted),     32'h1);
    check("req_all",           32'(allhalted),     32'h0);

    // Resume while halt request still high is ignored.
    dbg.resumereq = 2'b01;
    tick();
    dbg.resumereq = 2'b00;
    check("blk_halted", 32'(dbg.halted), 32'h1);
    check("blk_resume", 32'(dbg.resume), 32'h0);
    tick();
    check("blk_resume2", 32'(dbg.resume), 32'h0);

    // Accepted resume, running report two cycles later.
    dbg.haltreq   = 2'b00;
    dbg.resumereq = 2'b01;
    tick();
    dbg.resumereq = 2'b00;
    check("rsm_pulse",     32'(dbg.resume),    32'h1);
    check("rsm_ack_clear", 32'(dbg.resumeack), 32'h0);
    check("rsm_halted",    32'(dbg.halted),    32'h0);
    tick();
    check("rsm_pulse_end", 32'(dbg.resume),    32'h0);
    check("rsm_ack_wait",  32'(dbg.resumeack), 32'h0);
    dbg.hart_running = 2'b01;
    tick();
    dbg.hart_running = 2'b00;
    check("rsm_ack_set", 32'(dbg.resumeack), 32'h1);
    check("rsm_any",     32'(anyhalted),     32'h0);

    // Hart 1 breakpoint halt, hart 0 unsolicited halt in the same cycle.
    dbg.breakpoint = 2'b10;
    tick();
    dbg.breakpoint = 2'b00;
    check("bp_no_debug_req", 32'(dbg.debug_req), 32'h0);
    check("bp_pending",      32'(dbg.halted),    32'h0);
    dbg.hart_halted = 2'b11;
    tick();
    dbg.hart_halted = 2'b00;
    check("both_halted", 32'(dbg.halted), 32'h3);
    check("both_all",    32'(allhalted),  32'h1);
    check("both_cause",  32'(dbg.cause),  32'h0B);

    // Single step on hart 1 with a halt request arriving mid-step.
    dbg.step      = 2'b10;
    dbg.resumereq = 2'b10;
    tick();
    dbg.resumereq = 2'b00;
    check("stp_pulse", 32'(dbg.resume),    32'h2);
    check("stp_ack0",  32'(dbg.resumeack), 32'h1);
    dbg.hart_running = 2'b10;
    tick();
    dbg.hart_running = 2'b00;
    check("stp_ack",    32'(dbg.resumeack), 32'h3);
    check("stp_halted", 32'(dbg.halted),    32'h1);
    dbg.haltreq = 2'b10;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("stp_no_debug_req", 32'(dbg.debug_req), 32'h0);
    end
    dbg.hart_halted = 2'b10;
    tick();
    dbg.hart_halted = 2'b00;
    check("stp_halted_again", 32'(dbg.halted),    32'h3);
    check("stp_cause",        32'(dbg.cause),     32'h23);
    check("stp_debug_req",    32'(dbg.debug_req), 32'h0);
    check("stp_ack_sticky",   32'(dbg.resumeack), 32'h3);
    dbg.haltreq = 2'b00;
    dbg.step    = 2'b00;

    // Return hart 0 to running, then trigger and halt request together.
    dbg.resumereq = 2'b01;
    tick();
    dbg.resumereq = 2'b00;
    check("trg_ack_clear", 32'(dbg.resumeack), 32'h2);
    tick();
    dbg.hart_running = 2'b01;
    tick();
    dbg.hart_running = 2'b00;
    check("trg_running", 32'(dbg.halted),    32'h2);
    check("trg_ack",     32'(dbg.resumeack), 32'h3);
    dbg.trigger = 2'b01;
    dbg.haltreq = 2'b01;
    tick();
    dbg.trigger = 2'b00;
    check("trg_cause",     32'(dbg.cause),     32'h22);
    check("trg_debug_req", 32'(dbg.debug_req), 32'h0);
    check("trg_pending",   32'(dbg.halted),    32'h2);
    tick();
    check("trg_debug_req2", 32'(dbg.debug_req), 32'h0);

    // Reset while hart 0 is pending, with conflicting inputs active.
    rst             = 1'b1;
    dbg.haltreq     = 2'b11;
    dbg.hart_halted = 2'b11;
    tick();
    check("mrst_debug_req", 32'(dbg.debug_req), 32'h0);
    check("mrst_resume",    32'(dbg.resume),    32'h0);
    check("mrst_halted",    32'(dbg.halted),    32'h0);
    check("mrst_resumeack", 32'(dbg.resumeack), 32'h0);
    check("mrst_cause",     32'(dbg.cause),     32'h0);
    check("mrst_any",       32'(anyhalted),     32'h0);
    check("mrst_all",       32'(allhalted),     32'h0);
    check("mrst_hartinfo",  hartinfo,           32'h0021_2380);
    rst             = 1'b0;
    dbg.haltreq     = 2'b00;
    dbg.hart_halted = 2'b00;
    tick();
    check("post_rst_halted",    32'(dbg.halted),    32'h0);
    check("post_rst_debug_req", 32'(dbg.debug_req), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
